// File: rtl/pc_pkg.sv
// pc_pkg: shared types and helpers for the program-counter unit.
// Holds the FSM state enum, default address width / reset vector and the
// address aligner used on every redirect target.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_t;

    localparam int          PC_XLEN_DEFAULT      = 32;
    localparam logic [31:0] PC_RESET_VEC_DEFAULT = 32'h0000_0000;

    // Widest address the aligner handles; callers cast to their own XLEN.
    localparam int PC_ALIGN_W = 64;

    // Clear the low lsb_bits bits of an address.
    function automatic logic [PC_ALIGN_W-1:0] align(input logic [PC_ALIGN_W-1:0] addr,
                                                    input int unsigned          lsb_bits);
        logic [PC_ALIGN_W-1:0] mask;
        mask = '1;
        mask = mask << lsb_bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/pc_if.sv
// pc_if: fetch port between the PC unit and the instruction buffer.
// The PC unit is the master: it presents an address with fetch_valid and the
// buffer answers with fetch_ready.
interface pc_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_out;
    logic            fetch_valid;
    logic            fetch_ready;

    modport master (
        output pc_out,
        output fetch_valid,
        input  fetch_ready
    );

    modport slave (
        input  pc_out,
        input  fetch_valid,
        output fetch_ready
    );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC selection.
// Applies the RUN-state priority (ecall > mret > branch > advance > hold),
// forces IDLE / start-low to the reset vector and holds the PC in TRAP.
// The mret request arrives already gated by the top level, so this block
// is identical in both build flavours.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int              XLEN        = PC_XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(PC_RESET_VEC_DEFAULT),
    parameter int              INSTR_BYTES = 4
) (
    input  pc_state_t       state,
    input  logic            start,
    input  logic            ecall_detected,
    input  logic [XLEN-1:0] pc_ecall,
    input  logic            mret_req,
    input  logic [XLEN-1:0] epc_cur,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic [XLEN-1:0] pc_cur,
    output logic [XLEN-1:0] pc_next,
    output logic            epc_load
);

    localparam int unsigned ALIGN_BITS = $clog2(INSTR_BYTES);
    localparam logic [XLEN-1:0] STEP   = XLEN'(INSTR_BYTES);

    // Priority mux: redirects bypass stall/fetch_ready, advance only on a transfer.
    always_comb begin
        pc_next  = pc_cur;
        epc_load = 1'b0;
        if (!start) begin
            pc_next = RESET_VEC;
        end else begin
            case (state)
                IDLE: pc_next = RESET_VEC;
                RUN: begin
                    if (ecall_detected) begin
                        pc_next  = XLEN'(align(PC_ALIGN_W'(pc_ecall), ALIGN_BITS));
                        epc_load = 1'b1;
                    end else if (mret_req) begin
                        pc_next = XLEN'(align(PC_ALIGN_W'(epc_cur), ALIGN_BITS));
                    end else if (branch_taken) begin
                        pc_next = XLEN'(align(PC_ALIGN_W'(branch_target), ALIGN_BITS));
                    end else if (fetch_ready && !stall) begin
                        pc_next = pc_cur + STEP;
                    end
                end
                default: pc_next = pc_cur;
            endcase
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the RV32I core with instruction buffer.
// Holds the fetch address, advances it on each fetch-port transfer and applies
// branch, ecall-trap and (optionally) mret redirects.
// Build option: define PC_MRET_EN to enable mret and the EPC register;
// otherwise mret is ignored and epc_out is tied to zero.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN        = PC_XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(PC_RESET_VEC_DEFAULT),
    parameter int              INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            ecall_detected,
    input  logic [XLEN-1:0] pc_ecall,
    input  logic            mret,
    pc_if.master            fetch,
    output logic [XLEN-1:0] epc_out,
    output logic            running
);

    pc_state_t       state_q, state_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            running_q, running_d;
    logic [XLEN-1:0] pc_q, pc_next;
    logic [XLEN-1:0] epc_cur;
    logic            epc_load;
    logic            mret_req;

    // FSM state and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            fetch_valid_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            running_q     <= running_d;
        end
    end

    // Next state; status outputs are decoded from the next state so they
    // line up with the PC register on the same edge.
    always_comb begin
        state_d       = state_q;
        fetch_valid_d = 1'b0;
        running_d     = 1'b0;
        if (!start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = ecall_detected ? TRAP : RUN;
                TRAP:    state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
        fetch_valid_d = (state_d == RUN);
        running_d     = (state_d != IDLE);
    end

    pc_next_sel #(
        .XLEN        (XLEN),
        .RESET_VEC   (RESET_VEC),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_next_sel (
        .state          (state_q),
        .start          (start),
        .ecall_detected (ecall_detected),
        .pc_ecall       (pc_ecall),
        .mret_req       (mret_req),
        .epc_cur        (epc_cur),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .fetch_ready    (fetch.fetch_ready),
        .stall          (stall),
        .pc_cur         (pc_q),
        .pc_next        (pc_next),
        .epc_load       (epc_load)
    );

    // Fetch address register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_next;
        end
    end

`ifdef PC_MRET_EN
    logic [XLEN-1:0] epc_q;

    // Trap PC capture; held across IDLE so a later mret can still use it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc_q <= '0;
        end else if (epc_load) begin
            epc_q <= pc_q;
        end
    end

    assign mret_req = mret;
    assign epc_cur  = epc_q;
    assign epc_out  = epc_q;
`else
    logic unused_mret;

    assign unused_mret = mret ^ epc_load;
    assign mret_req    = 1'b0;
    assign epc_cur     = '0;
    assign epc_out     = '0;
`endif

    assign fetch.pc_out      = pc_q;
    assign fetch.fetch_valid = fetch_valid_q;
    assign running           = running_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed + randomized bench for pc_unit.
// A 32-bit instance is checked every cycle against a behavioural model; an
// 8-bit instance covers address wrap-around.
module tb_pc_unit;

`ifdef PC_MRET_EN
    localparam bit MRET_EN = 1'b1;
`else
    localparam bit MRET_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stall, branch_taken, ecall_detected, mret;
    logic [31:0] branch_target, pc_ecall;
    logic [31:0] epc_out;
    logic        running;

    logic        start8;
    logic [7:0]  epc8;
    logic        run8;

    int tests = 0;
    int fails = 0;

    // behavioural model: 0 = idle, 1 = run, 2 = trap bubble
    int          m_state;
    logic [31:0] m_pc, m_epc;

    always #5 clk = ~clk;

    pc_if #(.XLEN(32)) fetch ();
    pc_if #(.XLEN(8))  f8 ();

    pc_unit #(.XLEN(32), .RESET_VEC(32'h0), .INSTR_BYTES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .ecall_detected(ecall_detected), .pc_ecall(pc_ecall), .mret(mret),
        .fetch(fetch), .epc_out(epc_out), .running(running)
    );

    pc_unit #(.XLEN(8), .RESET_VEC(8'h0), .INSTR_BYTES(4)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(8'h0),
        .ecall_detected(1'b0), .pc_ecall(8'h0), .mret(1'b0),
        .fetch(f8), .epc_out(epc8), .running(run8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 32'h0;
        m_epc   = 32'h0;
    endtask

    // One clock edge of the specified behaviour, using the inputs currently driven.
    task automatic model_edge();
        if (!start) begin
            m_state = 0;
            m_pc    = 32'h0;
        end else if (m_state != 1) begin
            m_state = 1;      // idle starts running at the reset vector; trap bubble ends
        end else if (ecall_detected) begin
            m_epc   = m_pc;
            m_pc    = pc_ecall - (pc_ecall % 4);
            m_state = 2;
        end else if (MRET_EN && mret) begin
            m_pc = m_epc;
        end else if (branch_taken) begin
            m_pc = branch_target - (branch_target % 4);
        end else if (fetch.fetch_ready && !stall) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},      fetch.pc_out, m_pc);
        chk({tag, ".valid"},   32'(fetch.fetch_valid), 32'(m_state == 1));
        chk({tag, ".running"}, 32'(running), 32'(m_state != 0));
        chk({tag, ".epc"},     epc_out, MRET_EN ? m_epc : 32'h0);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        ecall_detected = 1'b0; mret = 1'b0; branch_target = '0; pc_ecall = '0;
        fetch.fetch_ready = 1'b0; f8.fetch_ready = 1'b0; start8 = 1'b0;
        model_reset();

        // reset state
        #1;
        check_all("reset");
        @(posedge clk); #1;
        check_all("reset_hold");
        @(negedge clk);
        reset = 1'b0;

        // start and four advances: 0, 4, 8, 12, 16
        start = 1'b1; fetch.fetch_ready = 1'b1;
        step("start");
        chk("first_fetch_pc", fetch.pc_out, 32'h0);
        chk("first_fetch_valid", 32'(fetch.fetch_valid), 32'h1);
        for (int i = 0; i < 4; i++) step("advance");
        chk("pc_after_4", fetch.pc_out, 32'h10);

        // not ready, then stalled too: hold 0x10
        fetch.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("not_ready");
        stall = 1'b1;
        step("stall_hold");
        chk("hold_pc", fetch.pc_out, 32'h10);

        // branch ignores stall/ready and aligns the target
        branch_taken = 1'b1; branch_target = 32'h203;
        step("branch");
        chk("branch_aligned", fetch.pc_out, 32'h200);
        stall = 1'b0; branch_target = 32'h24;
        step("branch_to_24");

        // ecall wins over a simultaneous branch
        ecall_detected = 1'b1; pc_ecall = 32'h100; branch_target = 32'h300;
        step("ecall");
        chk("ecall_pc", fetch.pc_out, 32'h100);
        chk("ecall_valid", 32'(fetch.fetch_valid), 32'h0);
        chk("ecall_epc", epc_out, MRET_EN ? 32'h24 : 32'h0);

        // trap bubble ignores the still-asserted branch
        ecall_detected = 1'b0; fetch.fetch_ready = 1'b1;
        step("trap_bubble");
        chk("bubble_pc", fetch.pc_out, 32'h100);
        branch_taken = 1'b0;
        step("after_trap");
        chk("after_trap_pc", fetch.pc_out, 32'h104);

        // mret returns to the saved PC only when enabled
        mret = 1'b1;
        step("mret");
        chk("mret_pc", fetch.pc_out, MRET_EN ? 32'h24 : 32'h108);
        mret = 1'b0;

        // start dropped at pc 0x40
        branch_taken = 1'b1; branch_target = 32'h40; fetch.fetch_ready = 1'b0;
        step("to_40");
        branch_taken = 1'b0; fetch.fetch_ready = 1'b1; start = 1'b0;
        step("start_drop");
        chk("drop_pc", fetch.pc_out, 32'h0);
        chk("drop_valid", 32'(fetch.fetch_valid), 32'h0);

        // 8-bit instance: 64 advances wrap 0xFC -> 0x00
        start8 = 1'b1; f8.fetch_ready = 1'b1;
        for (int k = 1; k <= 65; k++) begin
            step("idle32");
            chk("wrap8_pc", 32'(f8.pc_out), 32'((4 * (k - 1)) % 256));
        end
        chk("wrap8_running", 32'(run8), 32'h1);
        chk("wrap8_epc", 32'(epc8), 32'h0);
        start8 = 1'b0;

        // randomized phase against the model
        for (int n = 0; n < 400; n++) begin
            start             = ($urandom_range(0, 24) != 0);
            stall             = ($urandom_range(0, 3) == 0);
            fetch.fetch_ready = ($urandom_range(0, 2) != 0);
            ecall_detected    = ($urandom_range(0, 11) == 0);
            mret              = ($urandom_range(0, 9) == 0);
            branch_taken      = ($urandom_range(0, 6) == 0);
            branch_target     = $urandom;
            pc_ecall          = $urandom;
            step("random");
        end

        // asynchronous reset mid-operation
        start = 1'b1; stall = 1'b0; fetch.fetch_ready = 1'b1;
        ecall_detected = 1'b0; mret = 1'b0; branch_taken = 1'b0;
        step("pre_areset");
        step("pre_areset2");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        chk("async_reset_pc8", 32'(f8.pc_out), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RV32I core with the internal instruction buffer. It holds the fetch address, advances it under a valid/ready handshake with the instruction buffer and applies redirects: branch/jump, ecall trap vector and, optionally, mret return. Start gating and the reset vector are configurable. It sits between the control/hazard logic and the instruction-buffer fetch port.

## Interface
- XLEN, 32: address width in bits.
- RESET_VEC, 0: PC value after reset and while idle.
- INSTR_BYTES, 4: increment step; power of two, ≥ 2.
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  run enable; low forces the IDLE state.
- stall  in  1  hazard stall; holds PC when no redirect is present.
- branch_taken  in  1  branch/jump redirect request.
- branch_target  in  XLEN  redirect address.
- ecall_detected  in  1  trap request.
- pc_ecall  in  XLEN  trap vector.
- mret  in  1  trap return request (PC_MRET_EN only).
- fetch_ready  in  1  instruction buffer accepts the current PC.
- pc_out  out  XLEN  current fetch address.
- fetch_valid  out  1  pc_out is a valid fetch request.
- epc_out  out  XLEN  saved trap PC.
- running  out  1  high when the state is RUN or TRAP.

## Operation
- States:
  - IDLE: pc_out=RESET_VEC, fetch_valid=0.
  - RUN: fetch_valid=1.
  - TRAP: one-cycle flush bubble, fetch_valid=0.
- Transitions:
  - IDLE→RUN when start=1. pc_out stays at RESET_VEC, so the first fetch is RESET_VEC.
  - Any state→IDLE when start=0. pc_out goes to RESET_VEC and epc_out is held.
  - RUN→TRAP on ecall_detected.
  - TRAP→RUN unconditionally.
- Priority in RUN, highest first:
  1. ecall_detected: pc_out←pc_ecall, epc_out←pc_out.
  2. mret: pc_out←epc_out.
  3. branch_taken: pc_out←branch_target.
  4. Advance when fetch_ready & ~stall: pc_out←pc_out+INSTR_BYTES.
  5. Otherwise hold.
- Redirects ignore stall and fetch_ready. The pending request is squashed.
- Redirect targets have the low log2(INSTR_BYTES) bits forced to 0.
- Increment wraps modulo 2^XLEN.
- In TRAP all requests are ignored and pc_out is held.
- In IDLE all inputs except start are ignored.
- A valid fetch request (fetch_valid=1) keeps pc_out stable until it is accepted or a redirect occurs.

## Timing
- Reset values: pc_out=RESET_VEC, epc_out=0, fetch_valid=0, running=0, state=IDLE.
- Every output is registered. A redirect or advance is visible one cycle after the sampling edge.
- Handshake: a transfer happens on an edge where fetch_valid & fetch_ready & ~stall are all high. Exactly one address is consumed per transfer.
- Trap latency: ecall sampled at edge N → pc_out=pc_ecall and fetch_valid=0 after N; fetch_valid=1 after N+1.
- start deasserted at edge N → IDLE and pc_out=RESET_VEC after N, with no transfer on that edge.
- If reset asserts mid-operation, all outputs go to their reset values immediately, without waiting for clk.

## Configuration
- PC_MRET_EN defined: mret input is active and epc_out is driven from the EPC register.
- PC_MRET_EN undefined:
  - mret is ignored.
  - The EPC register is not instantiated and epc_out is tied to 0.
  - ecall still vectors to pc_ecall.

## Structure
- Shared package pc_pkg holds:
  - pc_state_t enum {IDLE, RUN, TRAP}
  - the default XLEN and RESET_VEC constants
  - an align function that clears the low bits of an address.
- One sub-module, pc_next_sel: the combinational priority mux and aligner that produces the next PC.
- The state register and the PC/EPC registers stay in pc_unit.

## Test plan
- Reset, then start=1 and fetch_ready=1 for 4 cycles → pc_out goes 0, 4, 8, 12, 16; fetch_valid=1 from the first RUN cycle.
- fetch_ready=0 for 3 cycles at pc 0x10 → pc_out holds 0x10. Raising stall=1 at the same time also holds it.
- branch_taken with target 0x203 while stall=1 and fetch_ready=0 → next pc_out=0x200.
- ecall with pc_ecall=0x100 at pc 0x24 → pc_out=0x100, epc_out=0x24, fetch_valid=0 for one cycle, then 0x104 after the next transfer. Simultaneous branch_taken is ignored.
- PC_MRET_EN build: mret after the trap above → pc_out=0x24. Non-MRET build: mret has no effect and epc_out=0.
- Check both of these boundaries:
  - start dropped at pc 0x40 → pc_out=0x0 and fetch_valid=0 next cycle.
  - XLEN=8 at pc 0xFC with an advance → pc_out=0x00.
